instr_sequencer: RTL

Program-side initiator for the 16-bit multi-cycle processor: holds a small loadable program memory and drives the processor's DIN/Run inputs, one instruction at a time, waiting on its Done.
Handles the two-word mvi form by presenting the immediate word after the opcode word.
Sits between the testbench/host load port and the processor; reports Busy, Finished and a Done-timeout Error.

---
 rtl/instr_sequencer_pkg.sv | 34 +++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer_prog_mem.sv | 26 ++
 rtl/instr_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared constants and types for the instruction sequencer
package instr_sequencer_pkg;

    localparam int DATA_W = 16;

    localparam int III_MSB = 15;
    localparam int III_LSB = 13;
    localparam int XXX_MSB = 12;
    localparam int XXX_LSB = 10;
    localparam int YYY_MSB = 9;
    localparam int YYY_LSB = 7;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    function automatic logic is_mvi(input logic [DATA_W-1:0] word);
        return word[III_MSB:III_LSB] == OP_MVI;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - host load port and processor-side signals of the sequencer
interface instr_sequencer_if
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              LoadEn;
    logic [ADDR_W-1:0] LoadAddr;
    logic [DATA_W-1:0] LoadData;
    logic [ADDR_W:0]   ProgLen;
    logic              Start;
    logic              Done;
    logic [DATA_W-1:0] DIN;
    logic              Run;
    logic              Busy;
    logic              Finished;
    logic              Error;
    logic [ADDR_W-1:0] PC;

    modport master (
        input  LoadEn, LoadAddr, LoadData, ProgLen, Start, Done,
        output DIN, Run, Busy, Finished, Error, PC
    );

    modport slave (
        output LoadEn, LoadAddr, LoadData, ProgLen, Start, Done,
        input  DIN, Run, Busy, Finished, Error, PC
    );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// rtl/instr_sequencer_prog_mem.sv - program memory, one sync write port, two async read ports
module seq_prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues stored instructions to the processor one at a time, waiting on Done
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    instr_sequencer_if.master  bus
);
    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] PC_TWO  = (ADDR_W+1)'(2);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_pc, w_pc_nxt;
    logic [ADDR_W:0]   r_len, w_len_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              r_fin, w_fin_nxt;

    logic [DATA_W-1:0] w_word, w_imm, w_din;
    logic [ADDR_W:0]   w_pc_inc1, w_pc_step, w_len_in;
    logic              w_mvi, w_trunc, w_busy, w_run, w_mem_we;

    assign w_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_GAP);
    assign w_mem_we  = bus.LoadEn && !w_busy;
    assign w_pc_inc1 = r_pc + PC_ONE;
    assign w_mvi     = is_mvi(w_word);
    assign w_pc_step = w_mvi ? (r_pc + PC_TWO) : w_pc_inc1;
    // An mvi whose immediate would fall past the program end cannot be issued.
    assign w_trunc   = w_mvi && (w_pc_inc1 >= r_len);
    assign w_len_in  = (bus.ProgLen > DEPTH) ? DEPTH : bus.ProgLen;

    seq_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
        .i_clk    (Clock),
        .i_we     (w_mem_we),
        .i_waddr  (bus.LoadAddr),
        .i_wdata  (bus.LoadData),
        .i_raddr0 (r_pc[ADDR_W-1:0]),
        .o_rdata0 (w_word),
        .i_raddr1 (w_pc_inc1[ADDR_W-1:0]),
        .o_rdata1 (w_imm)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_fin   <= w_fin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        w_cnt_nxt   = '0;
        w_err_nxt   = r_err;
        w_fin_nxt   = 1'b0;
        w_run       = 1'b0;
        w_din       = '0;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (bus.Start) begin
                    w_err_nxt = 1'b0;
                    w_pc_nxt  = '0;
                    w_len_nxt = w_len_in;
                    if (w_len_in == '0) begin
                        w_fin_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_trunc) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_run       = 1'b1;
                    w_din       = w_word;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_run = 1'b1;
                w_din = w_mvi ? w_imm : w_word;
                if (bus.Done) begin
                    w_pc_nxt = w_pc_step;
                    if (w_pc_step >= r_len) begin
                        w_fin_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_ISSUE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.DIN      = w_din;
    assign bus.Run      = w_run;
    assign bus.Busy     = w_busy;
    assign bus.Finished = r_fin;
    assign bus.Error    = r_err;
    assign bus.PC       = r_pc[ADDR_W-1:0];
endmodule
